// File: rtl/rbm_gibbs_scheduler_pkg.sv
// rbm_gibbs_scheduler_pkg: state encoding and defaults shared by the Gibbs scheduler and its watchdog.
package rbm_gibbs_scheduler_pkg;
    localparam int K_W_DEF     = 8;
    localparam int TIMEOUT_DEF = 4096;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_F_RST = 3'd1,
        S_F_RUN = 3'd2,
        S_F_CAP = 3'd3,
        S_B_RST = 3'd4,
        S_B_RUN = 3'd5,
        S_B_CAP = 3'd6,
        S_DONE  = 3'd7
    } state_t;
endpackage

// File: rtl/rbm_pass_timer.sv
// rbm_pass_timer: per-pass watchdog; counts enabled cycles and flags the last allowed one.
module rbm_pass_timer #(
    parameter int TIMEOUT = 4096
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    logic [W-1:0] cnt_q, cnt_d;
    // TIMEOUT of zero disables the watchdog entirely
    assign expired = (TIMEOUT != 0) && enable && (cnt_q == W'(TIMEOUT - 1));
    always_comb begin
        cnt_d = clear ? '0 : (enable && !expired) ? cnt_q + 1'b1 : cnt_q;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/rbm_gibbs_scheduler.sv
// rbm_gibbs_scheduler: runs K Gibbs steps (v->h->v...) over a forward and a backward RBM layer,
// owning layer restarts, valid gating, operand/result registers and a per-pass watchdog.
module rbm_gibbs_scheduler
    import rbm_gibbs_scheduler_pkg::*;
#(
    parameter int VIS_DIM = 15,
    parameter int HID_DIM = 5,
    parameter int K_W     = K_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [K_W-1:0]     k_steps,
    input  logic [VIS_DIM-1:0] v_in,
    output logic               busy,
    output logic               done,
    output logic               timeout_err,
    output logic [K_W-1:0]     step_count,
    output logic [VIS_DIM-1:0] v_out,
    output logic [HID_DIM-1:0] h_out,
    output logic               fwd_reset,
    output logic               fwd_valid,
    output logic [VIS_DIM-1:0] fwd_in,
    input  logic [HID_DIM-1:0] fwd_out,
    input  logic               fwd_finish,
    output logic               bwd_reset,
    output logic               bwd_valid,
    output logic [HID_DIM-1:0] bwd_in,
    input  logic [VIS_DIM-1:0] bwd_out,
    input  logic               bwd_finish
);
    state_t state_q, state_d;
    logic [K_W-1:0] kreg_q, kreg_d, step_q, step_d;
    logic [VIS_DIM-1:0] v_q, v_d;
    logic [HID_DIM-1:0] h_q, h_d;
    logic terr_q, terr_d, busy_q, busy_d, done_q, done_d;
    logic fwd_reset_q, fwd_reset_d, fwd_valid_q, fwd_valid_d;
    logic bwd_reset_q, bwd_reset_d, bwd_valid_q, bwd_valid_d;
    logic wdog_expired;
    rbm_pass_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clock   (clock),
        .reset   (reset),
        .clear   (state_q == S_F_RST || state_q == S_B_RST),
        .enable  (state_q == S_F_RUN || state_q == S_B_RUN),
        .expired (wdog_expired)
    );
    always_comb begin
        state_d = state_q;
        kreg_d  = kreg_q;
        step_d  = step_q;
        v_d     = v_q;
        h_d     = h_q;
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d = S_F_RST;
                kreg_d  = k_steps;
                step_d  = '0;
                v_d     = v_in;
                terr_d  = 1'b0;
            end
            S_F_RST: state_d = S_F_RUN;
            S_F_RUN: begin
                state_d = fwd_finish ? S_F_CAP : wdog_expired ? S_DONE : S_F_RUN;
                terr_d  = terr_q | (!fwd_finish && wdog_expired);
            end
            S_F_CAP: begin
                h_d     = fwd_out;
                state_d = (kreg_q == '0 || step_q == kreg_q) ? S_DONE : S_B_RST;
            end
            S_B_RST: state_d = S_B_RUN;
            S_B_RUN: begin
                state_d = bwd_finish ? S_B_CAP : wdog_expired ? S_DONE : S_B_RUN;
                terr_d  = terr_q | (!bwd_finish && wdog_expired);
            end
            S_B_CAP: begin
                v_d     = bwd_out;
                step_d  = step_q + 1'b1;
                state_d = S_F_RST;
            end
            default: state_d = S_IDLE;
        endcase
        // Layer controls are decoded from the next state so they leave a flop glitch-free
        busy_d      = state_d != S_IDLE;
        done_d      = state_d == S_DONE;
        fwd_reset_d = !(state_d == S_F_RUN || state_d == S_F_CAP);
        fwd_valid_d = state_d == S_F_RUN;
        bwd_reset_d = !(state_d == S_B_RUN || state_d == S_B_CAP);
        bwd_valid_d = state_d == S_B_RUN;
    end
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            kreg_q      <= '0;
            step_q      <= '0;
            v_q         <= '0;
            h_q         <= '0;
            terr_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fwd_reset_q <= 1'b1;
            fwd_valid_q <= 1'b0;
            bwd_reset_q <= 1'b1;
            bwd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            kreg_q      <= kreg_d;
            step_q      <= step_d;
            v_q         <= v_d;
            h_q         <= h_d;
            terr_q      <= terr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fwd_reset_q <= fwd_reset_d;
            fwd_valid_q <= fwd_valid_d;
            bwd_reset_q <= bwd_reset_d;
            bwd_valid_q <= bwd_valid_d;
        end
    end
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign step_count  = step_q;
    assign v_out       = v_q;
    assign h_out       = h_q;
    assign fwd_reset   = fwd_reset_q;
    assign fwd_valid   = fwd_valid_q;
    assign fwd_in      = v_q;
    assign bwd_reset   = bwd_reset_q;
    assign bwd_valid   = bwd_valid_q;
    assign bwd_in      = h_q;
endmodule
